// File: rtl/riscv_pkg.sv
// Shared definitions for the PC sequencer slice:
// sequencer states, branch funct3 codes and default width.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond.sv
// Conditional-branch resolution from ALU flags.
// Reserved funct3 codes never take and flag illegal.
module branch_cond
    import riscv_pkg::*;
(
    input  logic       branch,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       illegal
);

    // Select the condition for the decoded branch type.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (branch) begin
            case (funct3)
                F3_BEQ:  taken = zero;
                F3_BNE:  taken = !zero;
                F3_BLT:  taken = lt;
                F3_BGE:  taken = !lt;
                F3_BLTU: taken = ltu;
                F3_BGEU: taken = !ltu;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: owns the PC, runs the fetch
// handshake and resolves branches/jumps once per instruction.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter int                  XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]     RESET_PC = '0,
    parameter int                  CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_valid,
    output logic             instr_valid,
    input  logic             branch,
    input  logic             jump,
    input  logic             jalr,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  alu_result,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             pc_src,
    output logic             illegal_br,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_q;
    logic              iv_q;
    logic              br_taken;
    logic              br_illegal;
    logic              redirect;
    logic              in_exec;

    branch_cond u_branch_cond (
        .branch  (branch),
        .funct3  (funct3),
        .zero    (zero),
        .lt      (lt),
        .ltu     (ltu),
        .taken   (br_taken),
        .illegal (br_illegal)
    );

    assign in_exec     = (state_q == EXEC);
    assign redirect    = jalr | jump | br_taken;
    assign pc_src      = redirect & in_exec;
    assign illegal_br  = br_illegal & in_exec;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + FOUR;
    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign instr_valid = iv_q;
    assign taken_cnt   = cnt_q;

    // Next-PC mux: jalr beats jump beats taken branch.
    always_comb begin
        pc_d = pc_plus4;
        if (jalr) begin
            pc_d = {alu_result[XLEN-1:1], 1'b0};
        end else if (jump || br_taken) begin
            pc_d = pc_q + imm;
        end
    end

    // Sequencer FSM with registered handshake outputs, PC and counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            iv_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_valid) begin
                        state_q <= EXEC;
                        req_q   <= 1'b0;
                        iv_q    <= 1'b1;
                    end
                end
                EXEC: begin
                    iv_q <= 1'b0;
                    pc_q <= pc_d;
                    if (redirect && (cnt_q != '1)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (run) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    iv_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes expected
// results from an operand-level model, monitor pops on instr_valid.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic        instr_valid;
    logic        branch, jump, jalr;
    logic [2:0]  funct3;
    logic        zero, lt, ltu;
    logic [31:0] imm, alu_result;
    logic [31:0] pc, pc_plus4;
    logic        pc_src, illegal_br;
    logic [3:0]  taken_cnt;

    pc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .instr_valid(instr_valid),
        .branch(branch), .jump(jump), .jalr(jalr),
        .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
        .imm(imm), .alu_result(alu_result),
        .pc(pc), .pc_plus4(pc_plus4), .pc_src(pc_src),
        .illegal_br(illegal_br), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        src;
        logic        ill;
        logic [31:0] nxt;
        int          cnt;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mpc;
    int          mcnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: branch outcome from the source operands themselves.
    function automatic logic cond_holds(input logic [2:0] f3,
                                        input logic [31:0] a, b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic start();
        run = 1'b1;
        step();
    endtask

    // Issue one instruction from FETCH; leaves DUT in FETCH or IDLE.
    task automatic instr(input logic br, input logic j, input logic jr,
                         input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] alu,
                         input int dly, input logic run_after);
        exp_t e;
        logic tk;
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, mpc);
        for (int i = 0; i < dly; i++) begin
            step();
            chk("fetch_hold", {31'd0, imem_req}, 32'd1);
        end
        branch = br; jump = j; jalr = jr; funct3 = f3;
        zero = (a == b);
        lt = ($signed(a) < $signed(b));
        ltu = (a < b);
        imm = im; alu_result = alu;
        tk = br && cond_holds(f3, a, b);
        e.pc  = mpc;
        e.ill = br && (f3 == 3'd2 || f3 == 3'd3);
        e.src = jr || j || tk;
        if (jr)
            e.nxt = alu & 32'hFFFF_FFFE;
        else if (j || tk)
            e.nxt = mpc + im;
        else
            e.nxt = mpc + 32'd4;
        if (e.src && mcnt < 15)
            mcnt++;
        e.cnt = mcnt;
        mpc = e.nxt;
        sbq.push_back(e);
        imem_valid = 1'b1;
        step();
        imem_valid = 1'b0;
        run = run_after;
        step();
    endtask

    task automatic seq(input int dly);
        instr(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, dly, 1'b1);
    endtask

    task automatic goto_pc(input logic [31:0] tgt);
        instr(0, 1, 0, 3'd0, 32'd0, 32'd0, tgt - mpc, 32'd0, 0, 1'b1);
    endtask

    task automatic brn(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
        instr(1, 0, 0, f3, a, b, 32'h20, 32'd0, 0, 1'b1);
    endtask

    // Monitor: compare each EXEC cycle, then the committed PC/counter.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) continue;
            if (instr_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_exec", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("exec_pc", pc, e.pc);
                    chk("exec_pc4", pc_plus4, e.pc + 32'd4);
                    chk("exec_req", {31'd0, imem_req}, 32'd0);
                    chk("pc_src", {31'd0, pc_src}, {31'd0, e.src});
                    chk("illegal_br", {31'd0, illegal_br}, {31'd0, e.ill});
                    @(negedge clk);
                    chk("next_pc", pc, e.nxt);
                    chk("taken_cnt", {28'd0, taken_cnt}, e.cnt);
                    chk("single_exec", {31'd0, instr_valid}, 32'd0);
                end
            end else begin
                chk("idle_pc_src", {31'd0, pc_src}, 32'd0);
                chk("idle_illegal", {31'd0, illegal_br}, 32'd0);
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        logic [31:0] a, b, im, alu;
        int r;
        reset = 1'b1; run = 1'b0; imem_valid = 1'b0;
        branch = 0; jump = 0; jalr = 0; funct3 = 0;
        zero = 0; lt = 0; ltu = 0; imm = 0; alu_result = 0;
        mpc = 32'h0; mcnt = 0;
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_iv", {31'd0, instr_valid}, 32'd0);
        chk("rst_cnt", {28'd0, taken_cnt}, 32'd0);
        reset = 1'b0;
        step();

        // Reach 0x40, then reset in the middle of the next fetch.
        start();
        goto_pc(32'h40);
        step();
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_cnt", {28'd0, taken_cnt}, 32'd0);
        mpc = 32'h0; mcnt = 0;
        run = 1'b0;
        imem_valid = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("late_valid_req", {31'd0, imem_req}, 32'd0);
        chk("late_valid_iv", {31'd0, instr_valid}, 32'd0);
        imem_valid = 1'b0;
        step();

        // Sequential stream, one instruction per two cycles.
        start();
        for (int i = 0; i < 4; i++) seq(0);

        // Branch matrix at 0x100 with imm 0x20.
        goto_pc(32'h100); brn(3'd0, 32'd5, 32'd5);
        goto_pc(32'h100); brn(3'd1, 32'd5, 32'd5);
        goto_pc(32'h100); brn(3'd4, 32'hFFFF_FFFF, 32'd0);
        goto_pc(32'h100); brn(3'd7, 32'd0, 32'd1);
        goto_pc(32'h100); brn(3'd2, 32'd1, 32'd2);
        goto_pc(32'h100); brn(3'd3, 32'd1, 32'd1);

        // Backward jump, then jalr overriding jump.
        goto_pc(32'h200);
        instr(0, 1, 0, 3'd0, 0, 0, 32'hFFFF_FFF0, 0, 0, 1'b1);
        instr(0, 1, 1, 3'd0, 0, 0, 32'h40, 32'h333, 0, 1'b1);

        // PC wrap and counter saturation.
        goto_pc(32'hFFFF_FFFC);
        seq(1);
        for (int i = 0; i < 17; i++)
            instr(0, 1, 0, 3'd0, 0, 0, 32'd4, 0, 0, 1'b1);

        // Run drops during a slow fetch: finish it, then idle.
        run = 1'b0;
        instr(0, 0, 0, 3'd0, 0, 0, 0, 0, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("idle_req", {31'd0, imem_req}, 32'd0);
            chk("idle_pc_hold", pc, mpc);
            step();
        end

        // Randomized traffic; counter is saturated so also reset it.
        reset = 1'b1;
        #1 reset = 1'b0;
        mpc = 32'h0; mcnt = 0;
        step();
        start();
        for (int n = 0; n < 250; n++) begin
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            im = $urandom() & 32'hFFFF_FFFC;
            alu = $urandom();
            r = $urandom_range(0, 9);
            if (r <= 5)
                instr(1, 0, 0, 3'($urandom_range(0, 7)), a, b, im, alu,
                      $urandom_range(0, 3), 1'b1);
            else if (r == 6)
                instr(0, 1, 0, 3'd0, a, b, im, alu, $urandom_range(0, 2), 1'b1);
            else if (r == 7)
                instr(0, 0, 1, 3'd0, a, b, im, alu, $urandom_range(0, 2), 1'b1);
            else if (r == 8)
                instr(0, 0, 0, 3'($urandom_range(0, 7)), a, b, im, alu, 0, 1'b1);
            else
                instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      a, b, im, alu, $urandom_range(0, 1), 1'b1);
            if ($urandom_range(0, 7) == 0) begin
                run = 1'b0;
                step();
                step();
                start();
            end
        end
        run = 1'b0;
        repeat (4) step();
        chk("sb_empty", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
